// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM; fixed two-cycle req-to-ack.
// Build option: define ARB_FIXED_PRIO_EN for fixed M0 priority (default is round-robin).
module mem_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              rr_prio;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              take;
  logic              win;
  logic              tie_win;

  // Tie-break choice: rr_prio holds the master favoured on the next simultaneous request.
`ifdef ARB_FIXED_PRIO_EN
  assign tie_win = 1'b0;
`else
  assign tie_win = rr_prio;
`endif

  // Grant decision for the next edge; RESP hands off only to the non-owner.
  always_comb begin
    take = 1'b0;
    win  = 1'b0;
    case (state)
      IDLE: begin
        take = m0_req | m1_req;
        win  = (m0_req && m1_req) ? tie_win : m1_req;
      end
      RESP: begin
        win = ~owner;
`ifdef ARB_FIXED_PRIO_EN
        // M1 is never handed the bus straight after M0, so M0 keeps winning while it requests.
        take = owner & m0_req;
`else
        take = owner ? m0_req : m1_req;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rr_prio   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (take) begin
            state     <= ACC;
            busy      <= 1'b1;
            owner     <= win;
            rr_prio   <= ~win;
            ram_en    <= 1'b1;
            ram_we    <= win ? m1_we : m0_we;
            lat_addr  <= win ? m1_addr : m0_addr;
            lat_wdata <= win ? m1_wdata : m0_wdata;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ACC: begin
          state  <= RESP;
          busy   <= 1'b1;
          m0_ack <= ~owner;
          m1_ack <= owner;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;

  // RAM data only arrives during RESP, so it is steered to the acked master without a register stage.
  assign m0_rdata = m0_ack ? ram_rdata : '0;
  assign m1_rdata = m1_ack ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked against a
// transaction-level timing/memory model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;

  logic              clk;
  logic              rst_n;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ack, m1_ack;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy, owner;

  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;
  logic [DATA_W-1:0] ram [DEPTH];

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port RAM with one-cycle read latency and a preload port.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  // Reference model: one access occupies two cycles after its grant edge.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                cyc, free_at, grant_cyc;
  bit                granted, prio, m_owner, t_we;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  bit                served[$];
  int                errors, checks;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    grant_cyc = -100;
    free_at   = 0;
    granted   = 1'b0;
    prio      = 1'b0;
    m_owner   = 1'b0;
  endtask

  task automatic tick();
    bit r0, r1, c0, c1, w, resp_edge, we0, we1, e_en, e_ack, e_busy;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    int phase;
    r0 = m0_req; r1 = m1_req; we0 = m0_we; we1 = m1_we;
    a0 = m0_addr; a1 = m1_addr; d0 = m0_wdata; d1 = m1_wdata;
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else if (cyc >= free_at) begin
      c0 = r0; c1 = r1;
      resp_edge = granted && (cyc == free_at);
      if (resp_edge) begin
        if (m_owner) c1 = 1'b0;
        else         c0 = 1'b0;
      end
`ifdef ARB_FIXED_PRIO_EN
      if (resp_edge && !m_owner) c1 = 1'b0;
      w = !c0;
`else
      w = (c0 && c1) ? prio : c1;
`endif
      if (c0 || c1) begin
        m_owner = w; grant_cyc = cyc; free_at = cyc + 2; granted = 1'b1; prio = ~w;
        t_we = w ? we1 : we0; t_addr = w ? a1 : a0; t_wdata = w ? d1 : d0;
      end
    end
    #1;
    phase  = cyc - grant_cyc;
    e_en   = rst_n && (phase == 0);
    e_ack  = rst_n && (phase == 1);
    e_busy = e_en || e_ack;
    chk("busy", 64'(busy), 64'(e_busy));
    chk("ram_en", 64'(ram_en), 64'(e_en));
    chk("m0_ack", 64'(m0_ack), 64'(e_ack && !m_owner));
    chk("m1_ack", 64'(m1_ack), 64'(e_ack && m_owner));
    if (e_en) begin
      chk("ram_we", 64'(ram_we), 64'(t_we));
      chk("ram_addr", 64'(ram_addr), 64'(t_addr));
      chk("owner", 64'(owner), 64'(m_owner));
      if (t_we) chk("ram_wdata", 64'(ram_wdata), 64'(t_wdata));
    end
    if (!rst_n) chk("owner_rst", 64'(owner), 64'd0);
    if (e_ack && !m_owner) begin
      if (!t_we) chk("m0_rdata", 64'(m0_rdata), 64'(ref_mem[t_addr]));
    end else chk("m0_rdata_zero", 64'(m0_rdata), 64'd0);
    if (e_ack && m_owner) begin
      if (!t_we) chk("m1_rdata", 64'(m1_rdata), 64'(ref_mem[t_addr]));
    end else chk("m1_rdata_zero", 64'(m1_rdata), 64'd0);
    if (e_ack) begin
      served.push_back(m_owner);
      if (t_we) ref_mem[t_addr] = t_wdata;
    end
  endtask

  task automatic issue(input bit m, input bit we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    if (m) begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic wait_ack(input bit m, output int lat, output logic [DATA_W-1:0] data);
    lat = 0; data = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if ((m ? m1_ack : m0_ack) === 1'b1) begin
        lat = i; data = m ? m1_rdata : m0_rdata;
        break;
      end
    end
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
    chk("ack_timeout", 64'(lat != 0), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (m0_req || m1_req); i++) begin
      tick();
      if (m0_ack) m0_req = 1'b0;
      if (m1_ack) m1_req = 1'b0;
    end
    chk("drain", 64'(m0_req || m1_req), 64'd0);
    tick();
  endtask

  task automatic do_reset(input int n, input bit live);
    rst_n = 1'b0;
    model_reset();
    if (live) begin
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ram_en", 64'(ram_en), 64'd0);
      chk("rst_acks", 64'({m0_ack, m1_ack}), 64'd0);
    end
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [DATA_W-1:0] data;
    errors = 0; checks = 0; cyc = 0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    rst_n = 1'b0;
    model_reset();

    // Preload RAM and reference while in reset.
    pl_en = 1'b1;
    for (int a = 0; a < int'(DEPTH); a++) begin
      pl_addr = ADDR_W'(a);
      pl_data = (a == 3) ? 32'hDEADBEEF : $urandom;
      ref_mem[a] = pl_data;
      tick();
    end
    pl_en = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single read.
    issue(1'b0, 1'b0, ADDR_W'(3), '0);
    wait_ack(1'b0, lat, data);
    chk("lat_read", 64'(lat), 64'd2);
    chk("read_word3", 64'(data), 64'h0000_0000_DEAD_BEEF);
    tick();

    // m1 write then m0 read of the same word (m0 handed the bus in m1's RESP).
    issue(1'b1, 1'b1, ADDR_W'(5), 32'h12345678);
    wait_ack(1'b1, lat, data);
    chk("lat_write", 64'(lat), 64'd2);
    issue(1'b0, 1'b0, ADDR_W'(5), '0);
    wait_ack(1'b0, lat, data);
    chk("lat_handoff", 64'(lat), 64'd2);
    chk("write_then_read", 64'(data), 64'h0000_0000_1234_5678);
    tick();

    // Address changed during ACC must not disturb the access.
    issue(1'b0, 1'b0, ADDR_W'(3), '0);
    tick();
    m0_addr = ADDR_W'(7);
    chk("stable_addr", 64'(ram_addr), 64'd3);
    tick();
    chk("stable_ack", 64'(m0_ack), 64'd1);
    chk("stable_rdata", 64'(m0_rdata), 64'h0000_0000_DEAD_BEEF);
    m0_req = 1'b0;
    tick();

    // Both masters requesting continuously, from a fresh reset.
    do_reset(2, 1'b1);
    served.delete();
    issue(1'b0, 1'b0, ADDR_W'($urandom_range(0, 63)), '0);
    issue(1'b1, 1'b0, ADDR_W'($urandom_range(0, 63)), '0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m0_ack) m0_addr = ADDR_W'($urandom_range(0, 63));
      if (m1_ack) m1_addr = ADDR_W'($urandom_range(0, 63));
    end
    drain();
    chk("cont_count", 64'(served.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < served.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
      chk("cont_order", 64'(served[i]), 64'd0);
`else
      chk("cont_order", 64'(served[i]), 64'(i % 2));
`endif
    end

    // Reset during ACC, then a tie after release goes to m0 first.
    issue(1'b0, 1'b0, ADDR_W'(3), '0);
    tick();
    do_reset(2, 1'b1);
    m0_req = 1'b0;
    tick();
    issue(1'b0, 1'b0, ADDR_W'(3), '0);
    issue(1'b1, 1'b0, ADDR_W'(5), '0);
    tick();
    tick();
    chk("tie_m0_first", 64'(m0_ack), 64'd1);
    m0_req = 1'b0;
    wait_ack(1'b1, lat, data);
    chk("m1_after_reset", 64'(data), 64'h0000_0000_1234_5678);
    tick();

    // Random traffic from both masters.
    for (int i = 0; i < 400; i++) begin
      tick();
      if (m0_req && m0_ack) m0_req = 1'b0;
      else if (!m0_req && $urandom_range(0, 2) == 0)
        issue(1'b0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 63)), $urandom);
      if (m1_req && m1_ack) m1_req = 1'b0;
      else if (!m1_req && $urandom_range(0, 2) == 0)
        issue(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 63)), $urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
